// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bus: decode allocation, ALU/load write-back requests,
// read-stage hazard query and the registered register-file write port.
interface regfile_wb_scheduler_if;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic [1:0]  mem_size;
    logic [4:0]  rd_reg_1;
    logic [4:0]  rd_reg_2;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    modport master (
        output alloc_valid, alloc_reg,
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data, mem_size,
        output rd_reg_1, rd_reg_2,
        input  alu_ready, mem_ready, stall,
        input  wr_en, wr_reg, wr_data, wr_mask
    );

    modport slave (
        input  alloc_valid, alloc_reg,
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data, mem_size,
        input  rd_reg_1, rd_reg_2,
        output alu_ready, mem_ready, stall,
        output wr_en, wr_reg, wr_data, wr_mask
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and load write-backs onto a single register-file write port
// and tracks in-flight destinations in a pending scoreboard for read-stage stalls.
module regfile_wb_scheduler (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_scheduler_if.slave  bus
);

    logic        prio;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        alu_gnt;
    logic        mem_gnt;

    logic        vld_p1;
    logic [4:0]  reg_p1;
    logic [31:0] data_p1;
    logic [3:0]  mask_p1;

    function automatic logic [3:0] load_mask(input logic [1:0] size);
        case (size)
            2'b01:   return 4'b0011;
            2'b10:   return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    // Grant stage: prio only breaks ties, a lone requester always wins.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && (!bus.mem_valid || !prio))
                alu_gnt = 1'b1;
            else if (bus.mem_valid)
                mem_gnt = 1'b1;
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;
    assign bus.stall     = pending[bus.rd_reg_1] | pending[bus.rd_reg_2];

    // Allocation is applied after the commit clear so a same-index set wins.
    always_comb begin
        pending_nxt = pending;
        if (vld_p1)
            pending_nxt[reg_p1] = 1'b0;
        if (bus.alloc_valid && (bus.alloc_reg != 5'd0))
            pending_nxt[bus.alloc_reg] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Write stage (p1): registered register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            reg_p1  <= 5'd0;
            data_p1 <= 32'd0;
            mask_p1 <= 4'd0;
            pending <= 32'd0;
            prio    <= 1'b0;
        end else begin
            pending <= pending_nxt;
            vld_p1  <= (alu_gnt && (bus.alu_reg != 5'd0)) ||
                       (mem_gnt && (bus.mem_reg != 5'd0));
            if (alu_gnt) begin
                reg_p1  <= bus.alu_reg;
                data_p1 <= bus.alu_data;
                mask_p1 <= 4'b1111;
                prio    <= 1'b1;
            end else if (mem_gnt) begin
                reg_p1  <= bus.mem_reg;
                data_p1 <= bus.mem_data;
                mask_p1 <= load_mask(bus.mem_size);
                prio    <= 1'b0;
            end
        end
    end

    assign bus.wr_en   = vld_p1;
    assign bus.wr_reg  = reg_p1;
    assign bus.wr_data = data_p1;
    assign bus.wr_mask = mask_p1;

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (all state on its rising edge) and rst.
REQ-002 SHALL have no parameters: widths fixed at 32-bit data, 5-bit register index, 32 registers.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 alloc_valid  input  1  decode claims a destination register this cycle.
REQ-006 alloc_reg  input  5  claimed destination index.
REQ-007 alu_valid  input  1  ALU write-back request.
REQ-008 alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-009 alu_reg  input  5  ALU destination.
REQ-010 alu_data  input  32  ALU result.
REQ-011 mem_valid  input  1  load write-back request.
REQ-012 mem_ready  output  1  load request granted this cycle (combinational).
REQ-013 mem_reg  input  5  load destination.
REQ-014 mem_data  input  32  load data, right-aligned.
REQ-015 mem_size  input  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-016 rd_reg_1  input  5  read-stage source index 1.
REQ-017 rd_reg_2  input  5  read-stage source index 2.
REQ-018 stall  output  1  read stage must hold (combinational from pending state).
REQ-019 wr_en  output  1  register-file write strobe (registered).
REQ-020 wr_reg  output  5  write index (registered).
REQ-021 wr_data  output  32  write data (registered).
REQ-022 wr_mask  output  4  byte-lane enables, bit0 = bits 7:0 (registered).

Function
REQ-023 Grant: at most one requester is granted per cycle; ready is high only in the cycle its request is granted.
REQ-024 Single valid requester SHALL be granted in that cycle.
REQ-025 Both valid: grant the requester selected by 1-bit prio (0 = ALU, 1 = load).
REQ-026 After any grant, prio SHALL point to the non-granted requester; prio unchanged when nothing is granted.
REQ-027 A request not granted SHALL be held stable by the requester until ready; the block requires no other flow control.
REQ-028 Latency: request granted in cycle N drives wr_en/wr_reg/wr_data/wr_mask in cycle N+1; wr_en low in any cycle following a cycle with no grant.
REQ-029 Mask: ALU grant -> 1111; load word/11 -> 1111, half -> 0011, byte -> 0001; wr_data = requester data unmodified.
REQ-030 Register 0: a grant to reg 0 SHALL assert ready but SHALL leave wr_en low in N+1.
REQ-031 Scoreboard: 32-bit pending vector; alloc_valid with alloc_reg != 0 sets pending[alloc_reg] at the clock edge.
REQ-032 pending[wr_reg] SHALL clear at the edge ending the wr_en cycle (same edge on which the register file commits).
REQ-033 Simultaneous set and clear of the same index: set wins (bit remains 1).
REQ-034 pending[0] SHALL always read 0.
REQ-035 stall = pending[rd_reg_1] OR pending[rd_reg_2], from current registered state, no forwarding.

Reset
REQ-036 On rst at a clock edge: wr_en=0, wr_reg=0, wr_data=0, wr_mask=0, pending=0, prio=0; ready outputs SHALL be 0 while rst is high.
REQ-037 Reset mid-operation SHALL drop any in-flight write (wr_en low the cycle after reset) and discard all pending bits.

Verification
REQ-038 Alloc reg 5; read rd_reg_1=5 -> stall=1; ALU writes reg 5 data 0xDEADBEEF -> next cycle wr_en=1, wr_reg=5, wr_mask=1111; stall=0 the cycle after.
REQ-039 After reset, ALU and load both valid for 4 cycles -> grant order ALU, load, ALU, load; wr_en high on 4 consecutive cycles.
REQ-040 Load reg 9, mem_size=10, mem_data=0x000000AB -> wr_mask=0001, wr_data=0x000000AB; mem_size=01 -> wr_mask=0011.
REQ-041 ALU valid to reg 0 with data 0x1234 -> alu_ready=1, wr_en=0 next cycle; alloc of reg 0 -> stall never asserts for reg 0.
REQ-042 Alloc reg 7 in the same cycle a wr_en to reg 7 commits -> pending[7] stays 1, stall stays high for rd_reg_2=7.
REQ-043 Grant issued, rst asserted next edge -> wr_en=0, all pending cleared, prio=0 (next dual request grants ALU).
